// File: rtl/zstd_frame_header_parser.sv
`default_nettype none
// =====================================================================
// Module   : zstd_frame_header_parser
// Brief    : Zstandard frame-header decoder, LANES stream bytes per beat
// Revision : 1.0
// =====================================================================
module zstd_frame_header_parser #(
  parameter int LANES          = 2,
  parameter int MAX_WINDOW_LOG = 31
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [8*LANES-1:0]           in_data_i,
  output logic                         hdr_valid_o,
  input  logic                         hdr_ready_i,
  output logic                         skippable_o,
  output logic [1:0]                   err_o,
  output logic [7:0]                   fhd_o,
  output logic                         wd_present_o,
  output logic [2:0]                   did_bytes_o,
  output logic [3:0]                   fcs_bytes_o,
  output logic [31:0]                  dictionary_id_o,
  output logic [63:0]                  frame_content_size_o,
  output logic [63:0]                  window_size_o,
  output logic [8*LANES-1:0]           rem_data_o,
  output logic [$clog2(LANES+1)-1:0]   rem_count_o
);

  localparam int          RCW      = $clog2(LANES+1);
  localparam logic [31:0] c_MAGIC  = 32'hFD2FB528;
  localparam logic [27:0] c_SKIPHI = 28'h184D2A5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           pos_q, pos_d;
  logic [31:0]          magic_q, magic_d;
  logic                 skip_q, skip_d;
  logic [1:0]           err_q, err_d;
  logic [7:0]           fhd_q, fhd_d;
  logic                 wdp_q, wdp_d;
  logic [7:0]           wd_q, wd_d;
  logic [2:0]           db_q, db_d;
  logic [3:0]           fb_q, fb_d;
  logic [31:0]          did_q, did_d;
  logic [63:0]          fcs_q, fcs_d;
  logic [63:0]          win_q, win_d;
  logic [8*LANES-1:0]   rem_q, rem_d;
  logic [RCW-1:0]       rc_q, rc_d;

  logic                 w_done, w_fail;
  logic [3:0]           w_nrem;
  logic [8*LANES-1:0]   w_rem;
  logic [7:0]           w_byte;
  logic [5:0]           w_idx, w_off, w_fo, w_hlen, w_wlog;
  logic [63:0]          w_base;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      magic_q <= '0;
      skip_q  <= 1'b0;
      err_q   <= '0;
      fhd_q   <= '0;
      wdp_q   <= 1'b0;
      wd_q    <= '0;
      db_q    <= '0;
      fb_q    <= '0;
      did_q   <= '0;
      fcs_q   <= '0;
      win_q   <= '0;
      rem_q   <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      magic_q <= magic_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      fhd_q   <= fhd_d;
      wdp_q   <= wdp_d;
      wd_q    <= wd_d;
      db_q    <= db_d;
      fb_q    <= fb_d;
      did_q   <= did_d;
      fcs_q   <= fcs_d;
      win_q   <= win_d;
      rem_q   <= rem_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    magic_d = magic_q;
    skip_d  = skip_q;
    err_d   = err_q;
    fhd_d   = fhd_q;
    wdp_d   = wdp_q;
    wd_d    = wd_q;
    db_d    = db_q;
    fb_d    = fb_q;
    did_d   = did_q;
    fcs_d   = fcs_q;
    win_d   = win_q;
    rem_d   = rem_q;
    rc_d    = rc_q;
    w_done  = 1'b0;
    w_fail  = 1'b0;
    w_nrem  = '0;
    w_rem   = '0;
    w_byte  = '0;
    w_idx   = '0;
    w_off   = '0;
    w_fo    = '0;
    w_hlen  = '0;
    w_wlog  = '0;
    w_base  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COLLECT;
          pos_d   = '0;
          magic_d = '0;
          skip_d  = 1'b0;
          err_d   = '0;
          fhd_d   = '0;
          wdp_d   = 1'b0;
          wd_d    = '0;
          db_d    = '0;
          fb_d    = '0;
          did_d   = '0;
          fcs_d   = '0;
          win_d   = '0;
          rem_d   = '0;
          rc_d    = '0;
        end
      end
      S_COLLECT: begin
        if (in_valid_i) begin
          // Lanes are walked in stream order so a field decoded in a lower
          // lane (notably the FHD) already steers the lanes above it.
          for (int l = 0; l < LANES; l++) begin
            w_byte = in_data_i[8*l +: 8];
            w_idx  = pos_q + 6'(l);
            w_hlen = 6'd5 + {5'd0, wdp_d} + {3'd0, db_d} + {2'd0, fb_d};
            if (w_done) begin
              if (!w_fail) begin
                w_rem[{w_nrem[2:0], 3'b000} +: 8] = w_byte;
                w_nrem = w_nrem + 4'd1;
              end
            end else if (w_idx < 6'd4) begin
              magic_d[{w_idx[1:0], 3'b000} +: 8] = w_byte;
              if (w_idx == 6'd3) begin
                if (magic_d[31:4] == c_SKIPHI) begin
                  skip_d = 1'b1;
                end else if (magic_d != c_MAGIC) begin
                  err_d  = 2'd1;
                  w_done = 1'b1;
                  w_fail = 1'b1;
                end
              end
            end else if (skip_d) begin
              w_fo = w_idx - 6'd4;
              fcs_d[{w_fo[2:0], 3'b000} +: 8] = w_byte;
              if (w_idx == 6'd7) w_done = 1'b1;
            end else if (w_idx == 6'd4) begin
              fhd_d = w_byte;
              wdp_d = !w_byte[5];
              case (w_byte[1:0])
                2'd0:    db_d = 3'd0;
                2'd1:    db_d = 3'd1;
                2'd2:    db_d = 3'd2;
                default: db_d = 3'd4;
              endcase
              case (w_byte[7:6])
                2'd0:    fb_d = w_byte[5] ? 4'd1 : 4'd0;
                2'd1:    fb_d = 4'd2;
                2'd2:    fb_d = 4'd4;
                default: fb_d = 4'd8;
              endcase
              if (w_byte[3]) begin
                err_d  = 2'd2;
                w_done = 1'b1;
                w_fail = 1'b1;
              end
            end else begin
              w_off = w_idx - 6'd5;
              if (wdp_d && (w_off == 6'd0)) begin
                wd_d   = w_byte;
                w_wlog = 6'd10 + {1'b0, w_byte[7:3]};
                if (w_wlog > 6'(MAX_WINDOW_LOG)) begin
                  err_d  = 2'd3;
                  w_done = 1'b1;
                  w_fail = 1'b1;
                end
              end else begin
                w_off = w_off - {5'd0, wdp_d};
                if (w_off < {3'd0, db_d}) begin
                  did_d[{w_off[1:0], 3'b000} +: 8] = w_byte;
                end else begin
                  w_fo = w_off - {3'd0, db_d};
                  fcs_d[{w_fo[2:0], 3'b000} +: 8] = w_byte;
                end
              end
              if (!w_fail && (w_idx == w_hlen - 6'd1)) w_done = 1'b1;
            end
          end
          pos_d = pos_q + 6'(LANES);
          if (w_done) begin
            state_d = S_OUT;
            rem_d   = w_fail ? '0 : w_rem;
            rc_d    = w_fail ? '0 : w_nrem[RCW-1:0];
            if (!w_fail) begin
              // A two-byte FCS field is stored biased by 256.
              fcs_d  = fcs_d + ((fb_d == 4'd2) ? 64'd256 : 64'd0);
              w_wlog = 6'd10 + {1'b0, wd_d[7:3]};
              w_base = 64'd1 << w_wlog;
              if (skip_d)     win_d = '0;
              else if (wdp_d) win_d = w_base + (w_base >> 3) * {61'd0, wd_d[2:0]};
              else            win_d = fcs_d;
            end
          end
        end
      end
      S_OUT: begin
        if (hdr_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o           = (state_q == S_COLLECT);
  assign hdr_valid_o          = (state_q == S_OUT);
  assign skippable_o          = skip_q;
  assign err_o                = err_q;
  assign fhd_o                = fhd_q;
  assign wd_present_o         = wdp_q;
  assign did_bytes_o          = db_q;
  assign fcs_bytes_o          = fb_q;
  assign dictionary_id_o      = did_q;
  assign frame_content_size_o = fcs_q;
  assign window_size_o        = win_q;
  assign rem_data_o           = rem_q;
  assign rem_count_o          = rc_q;

endmodule
`default_nettype wire

// File: tb/tb_zstd_frame_header_parser.sv
`default_nettype none
// =====================================================================
// Module   : tb_zstd_frame_header_parser
// Brief    : Scoreboard bench for the frame-header parser (4- and 2-lane)
// Revision : 1.0
// =====================================================================
module tb_zstd_frame_header_parser;

  typedef struct {
    bit          full;
    logic        skip;
    logic [1:0]  err;
    logic [7:0]  fhd;
    logic        wdp;
    logic [2:0]  db;
    logic [3:0]  fb;
    logic [31:0] did;
    logic [63:0] fcs;
    logic [63:0] win;
    logic [63:0] rem;
    logic [3:0]  rc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 0, in_valid_a = 0, hdr_ready_a = 1;
  logic [31:0] in_data_a = '0;
  logic        in_ready_a, hdr_valid_a, skip_a, wdp_a;
  logic [1:0]  err_a;
  logic [7:0]  fhd_a;
  logic [2:0]  db_a;
  logic [3:0]  fb_a;
  logic [31:0] did_a, rem_a;
  logic [63:0] fcs_a, win_a;
  logic [2:0]  rc_a;

  logic        start_b = 0, in_valid_b = 0, hdr_ready_b = 1;
  logic [15:0] in_data_b = '0;
  logic        in_ready_b, hdr_valid_b, skip_b, wdp_b;
  logic [1:0]  err_b;
  logic [7:0]  fhd_b;
  logic [2:0]  db_b;
  logic [3:0]  fb_b;
  logic [31:0] did_b;
  logic [15:0] rem_b;
  logic [63:0] fcs_b, win_b;
  logic [1:0]  rc_b;

  zstd_frame_header_parser #(.LANES(4), .MAX_WINDOW_LOG(31)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .in_valid_i(in_valid_a),
    .in_ready_o(in_ready_a), .in_data_i(in_data_a), .hdr_valid_o(hdr_valid_a),
    .hdr_ready_i(hdr_ready_a), .skippable_o(skip_a), .err_o(err_a), .fhd_o(fhd_a),
    .wd_present_o(wdp_a), .did_bytes_o(db_a), .fcs_bytes_o(fb_a),
    .dictionary_id_o(did_a), .frame_content_size_o(fcs_a), .window_size_o(win_a),
    .rem_data_o(rem_a), .rem_count_o(rc_a)
  );

  zstd_frame_header_parser #(.LANES(2), .MAX_WINDOW_LOG(31)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .in_valid_i(in_valid_b),
    .in_ready_o(in_ready_b), .in_data_i(in_data_b), .hdr_valid_o(hdr_valid_b),
    .hdr_ready_i(hdr_ready_b), .skippable_o(skip_b), .err_o(err_b), .fhd_o(fhd_b),
    .wd_present_o(wdp_b), .did_bytes_o(db_b), .fcs_bytes_o(fb_b),
    .dictionary_id_o(did_b), .frame_content_size_o(fcs_b), .window_size_o(win_b),
    .rem_data_o(rem_b), .rem_count_o(rc_b)
  );

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(bit full, logic skip, logic [1:0] err, logic [7:0] fhd,
                              logic wdp, logic [2:0] db, logic [3:0] fb, logic [31:0] did,
                              logic [63:0] fcs, logic [63:0] win, logic [63:0] rem,
                              logic [3:0] rc);
    exp_t e;
    e.full = full; e.skip = skip; e.err = err; e.fhd = fhd; e.wdp = wdp; e.db = db;
    e.fb = fb; e.did = did; e.fcs = fcs; e.win = win; e.rem = rem; e.rc = rc;
    return e;
  endfunction

  task automatic check_out(input string p, input exp_t e, input logic skip, input logic [1:0] err,
                           input logic [7:0] fhd, input logic wdp, input logic [2:0] db,
                           input logic [3:0] fb, input logic [31:0] did, input logic [63:0] fcs,
                           input logic [63:0] win, input logic [63:0] rem, input logic [3:0] rc);
    cmp({p, ".err"}, 64'(err), 64'(e.err));
    cmp({p, ".skippable"}, 64'(skip), 64'(e.skip));
    cmp({p, ".rem_count"}, 64'(rc), 64'(e.rc));
    if (e.full) begin
      cmp({p, ".fhd"}, 64'(fhd), 64'(e.fhd));
      cmp({p, ".wd_present"}, 64'(wdp), 64'(e.wdp));
      cmp({p, ".did_bytes"}, 64'(db), 64'(e.db));
      cmp({p, ".fcs_bytes"}, 64'(fb), 64'(e.fb));
      cmp({p, ".dictionary_id"}, 64'(did), 64'(e.did));
      cmp({p, ".frame_content_size"}, fcs, e.fcs);
      if (!e.skip) cmp({p, ".window_size"}, win, e.win);
      cmp({p, ".rem_data"}, rem, e.rem);
    end
  endtask

  // Monitors: compare once on the first cycle each header result is presented.
  initial begin
    exp_t e;
    bit   seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (hdr_valid_a && !seen) begin
        seen = 1;
        if (qa.size() == 0) cmp("A.unexpected_hdr_valid", 64'd1, 64'd0);
        else begin
          e = qa.pop_front();
          check_out("A", e, skip_a, err_a, fhd_a, wdp_a, db_a, fb_a, did_a, fcs_a, win_a,
                    64'(rem_a), 4'(rc_a));
        end
      end else if (!hdr_valid_a) seen = 0;
    end
  end

  initial begin
    exp_t e;
    bit   seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (hdr_valid_b && !seen) begin
        seen = 1;
        if (qb.size() == 0) cmp("B.unexpected_hdr_valid", 64'd1, 64'd0);
        else begin
          e = qb.pop_front();
          check_out("B", e, skip_b, err_b, fhd_b, wdp_b, db_b, fb_b, did_b, fcs_b, win_b,
                    64'(rem_b), 4'(rc_b));
        end
      end else if (!hdr_valid_b) seen = 0;
    end
  end

  task automatic run_a(input logic [31:0] b0, b1, b2, b3, input int n, input exp_t e,
                       input bit gap, input int hold);
    logic [31:0] bt [4];
    int          cyc;
    logic [63:0] s_fcs;
    logic [31:0] s_rem;
    logic [1:0]  s_err;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    qa.push_back(e);
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        in_valid_a = 0;
        @(negedge clk);
      end
      in_valid_a = 1;
      in_data_a  = bt[i];
      cyc = 0;
      while (!in_ready_a && cyc < 20) begin @(negedge clk); cyc++; end
      if (cyc >= 20) cmp("A.beat_accept_timeout", 64'd1, 64'd0);
      @(negedge clk);
    end
    in_valid_a = 0;
    cmp("A.hdr_valid_latency", 64'(hdr_valid_a), 64'd1);
    cmp("A.in_ready_in_out", 64'(in_ready_a), 64'd0);
    if (hold > 0) begin
      hdr_ready_a = 0;
      s_fcs = fcs_a; s_rem = rem_a; s_err = err_a;
      for (int k = 0; k < hold; k++) begin
        in_valid_a = ~in_valid_a;
        in_data_a  = $urandom;
        @(negedge clk);
        cmp("HOLD.hdr_valid", 64'(hdr_valid_a), 64'd1);
        cmp("HOLD.in_ready", 64'(in_ready_a), 64'd0);
        cmp("HOLD.fcs_stable", fcs_a, s_fcs);
        cmp("HOLD.rem_stable", 64'(rem_a), 64'(s_rem));
        cmp("HOLD.err_stable", 64'(err_a), 64'(s_err));
      end
      in_valid_a  = 0;
      hdr_ready_a = 1;
    end
    cyc = 0;
    while (hdr_valid_a && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) cmp("A.handshake_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_b(input logic [15:0] b0, b1, b2, b3, input int n, input exp_t e);
    logic [15:0] bt [4];
    int          cyc;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    qb.push_back(e);
    @(negedge clk); start_b = 1;
    @(negedge clk); start_b = 0;
    for (int i = 0; i < n; i++) begin
      in_valid_b = 1;
      in_data_b  = bt[i];
      cyc = 0;
      while (!in_ready_b && cyc < 20) begin @(negedge clk); cyc++; end
      if (cyc >= 20) cmp("B.beat_accept_timeout", 64'd1, 64'd0);
      @(negedge clk);
    end
    in_valid_b = 0;
    cmp("B.hdr_valid_latency", 64'(hdr_valid_b), 64'd1);
    cyc = 0;
    while (hdr_valid_b && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) cmp("B.handshake_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    cmp("RST.in_ready", 64'(in_ready_a), 64'd0);
    cmp("RST.hdr_valid", 64'(hdr_valid_a), 64'd0);
    cmp("RST.fcs", fcs_a, 64'd0);
    cmp("RST.err", 64'(err_a), 64'd0);
    cmp("RST.b_in_ready", 64'(in_ready_b), 64'd0);
    rst_n = 1;

    // DID + window descriptor + 4-byte FCS, one remainder byte, input gaps
    run_a(32'hFD2FB528, 32'h10075881, 32'hAA000000, '0, 3,
          mk(1, 0, 0, 8'h81, 1, 1, 4, 7, 16, 64'd2097152, 64'hAA, 1), 1, 0);
    // WD 0x5A, two remainder bytes, result held with hdr_ready low
    run_a(32'hFD2FB528, 32'h44335A00, '0, '0, 2,
          mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 64'd2621440, 64'h4433, 2), 0, 5);
    // Window log 32 exceeds the limit
    run_a(32'hFD2FB528, 32'h2211B000, '0, '0, 2,
          mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    // Skippable frame with LE size 16
    run_a(32'h184D2A50, 32'h00000010, '0, '0, 2,
          mk(1, 1, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0), 0, 0);
    // Bad magic
    run_a(32'hFE2FB528, '0, '0, '0, 1,
          mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    // FHD reserved bit
    run_a(32'hFD2FB528, 32'h00000028, '0, '0, 2,
          mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    // 2-byte DID, 2-byte FCS (+256), last header byte in lane 0, three remainder bytes
    run_a(32'hFD2FB528, 32'h00123462, 32'hDDCCBB01, '0, 3,
          mk(1, 0, 0, 8'h62, 0, 2, 2, 32'h1234, 512, 512, 64'hDDCCBB, 3), 0, 0);
    // 8-byte FCS spanning three beats
    run_a(32'hFD2FB528, 32'h030201E0, 32'h07060504, 32'h33221108, 4,
          mk(1, 0, 0, 8'hE0, 0, 0, 8, 0, 64'h0807060504030201, 64'h0807060504030201,
             64'h332211, 3), 0, 0);

    // Two-lane instance
    run_b(16'hB528, 16'hFD2F, 16'h0520, '0, 3,
          mk(1, 0, 0, 8'h20, 0, 0, 1, 0, 5, 5, 0, 0));
    run_b(16'hB528, 16'hFD2F, 16'h0921, 16'h7705, 4,
          mk(1, 0, 0, 8'h21, 0, 1, 1, 9, 5, 5, 64'h77, 1));

    // Reset in the middle of a header
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0; in_valid_a = 1; in_data_a = 32'hFD2FB528;
    @(negedge clk); in_data_a = 32'h10075881;
    @(negedge clk); in_valid_a = 0;
    cmp("MID.fhd_decoded", 64'(fhd_a), 64'h81);
    rst_n = 0;
    #1;
    cmp("MID.rst_in_ready", 64'(in_ready_a), 64'd0);
    cmp("MID.rst_hdr_valid", 64'(hdr_valid_a), 64'd0);
    cmp("MID.rst_fhd", 64'(fhd_a), 64'd0);
    cmp("MID.rst_did", 64'(did_a), 64'd0);
    cmp("MID.rst_wdp", 64'(wdp_a), 64'd0);
    @(negedge clk); rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      cmp("MID.idle_no_start", 64'(in_ready_a), 64'd0);
    end
    run_a(32'hFD2FB528, 32'h00123462, 32'hDDCCBB01, '0, 3,
          mk(1, 0, 0, 8'h62, 0, 2, 2, 32'h1234, 512, 512, 64'hDDCCBB, 3), 0, 0);

    repeat (3) @(negedge clk);
    cmp("A.pending_expected", 64'(qa.size()), 64'd0);
    cmp("B.pending_expected", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zstd_frame_header_parser.md
# zstd_frame_header_parser

Parametrised Zstandard frame-header parser that accepts the compressed stream as LANES bytes per beat over a valid/ready handshake. It decodes the magic number, Frame_Header_Descriptor, Window_Descriptor, Dictionary_ID and Frame_Content_Size as true little-endian values. It also recognises skippable frames, computes Window_Size and flags malformed headers. It sits at the front of the decompressor, ahead of block parsing, and returns unconsumed bytes of the last beat to the downstream block parser.

## Interface
- LANES, 2, bytes per input beat; legal values 1, 2, 4, 8; lane 0 = in_data[7:0] = earliest byte
- MAX_WINDOW_LOG, 31, largest accepted window log (10+Exponent)
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse in IDLE begins a new frame header
- in_valid  in  1  in_data holds a beat
- in_ready  out  1  parser accepts the beat this cycle
- in_data  in  8*LANES  stream bytes
- hdr_valid  out  1  header result valid, held until hdr_ready
- hdr_ready  in  1  consumer takes result
- skippable  out  1  frame is skippable (magic 0x184D2A50..5F)
- err  out  2  0 none, 1 bad magic, 2 FHD reserved bit set, 3 window log > MAX_WINDOW_LOG
- fhd  out  8  Frame_Header_Descriptor
- wd_present  out  1  Window_Descriptor byte present
- did_bytes  out  3  0/1/2/4
- fcs_bytes  out  4  0/1/2/4/8
- dictionary_id  out  32  little-endian value
- frame_content_size  out  64  decoded FCS (2-byte field: +256); skippable: frame size
- window_size  out  64  decoded window size
- rem_data  out  8*LANES  unconsumed bytes of final beat, first one in lane 0, upper lanes zero
- rem_count  out  $clog2(LANES+1)  number of valid rem_data bytes

## Operation
- States: IDLE -> COLLECT (on start) -> OUT (last header byte accepted, or error detected) -> IDLE (hdr_valid && hdr_ready).
- in_ready = 1 only in COLLECT; beat accepted when in_valid && in_ready. Byte counter pos advances by LANES per accepted beat; each lane decoded by absolute byte index pos+lane.
- Bytes 0-3: magic, compared as 32-bit LE. 0xFD2FB528 -> normal frame. 0x184D2A5x -> skippable; bytes 4-7 = LE size into frame_content_size; header length 8. Otherwise err=1.
- Normal frame: byte 4 = FHD. Reserved bit FHD[3]=1 -> err=2. wd_present = !FHD[5]. did_bytes from FHD[1:0] = {0,1,2,4}. fcs_bytes from FHD[7:6] = {FHD[5]?1:0, 2, 4, 8}. Header length = 5 + wd_present + did_bytes + fcs_bytes. Header length uses the FHD byte from the same beat when the FHD arrives in it.
- Window: E = WD[7:3], M = WD[2:0]; base = 1<<(10+E); window_size = base + (base>>3)*M. 10+E > MAX_WINDOW_LOG -> err=3. Single-segment (no WD): window_size = frame_content_size.
- Remainder: in the beat holding the last header byte, the following bytes are packed into rem_data/rem_count; the last header byte may sit in any lane.
- Error: transition to OUT at the end of the beat that exposed it; that beat and later header bytes are discarded, rem_count=0. Fields already decoded keep their values.
- All fields are registered and stay stable in OUT. On IDLE -> COLLECT they clear to 0.

## Timing
- Reset (async assert, sync-release by system): state IDLE, in_ready=0, hdr_valid=0, every output 0.
- start is ignored outside IDLE. in_valid is ignored outside COLLECT.
- hdr_valid rises the cycle after the final header beat is accepted; latency = ceil(header_len/LANES) accepted beats + 1 cycle.
- hdr_valid held with all outputs stable while hdr_ready=0. Handshake cycle -> IDLE next cycle. A new start is accepted from the following cycle.
- in_valid gaps in COLLECT stall parsing without state loss.
- reset_n low mid-frame aborts at once; the parser restarts only on a new start.

## Test plan
- LANES=2; beats 28 B5, 2F FD, 20 05 -> hdr_valid after beat 3; fcs_bytes=1, frame_content_size=5, window_size=5, wd_present=0, rem_count=0, err=0.
- LANES=4; beats 28 B5 2F FD, 81 58 07 10, 00 00 00 AA -> dictionary_id=7, frame_content_size=16, window_size=2097152, rem_count=1, rem_data=0x000000AA.
- LANES=4; WD=0x5A, FHD=0x00 (other bytes as needed) -> window_size=2621440. WD=0xB0 with MAX_WINDOW_LOG=31 -> err=3.
- LANES=4; beats 50 2A 4D 18, 10 00 00 00 -> skippable=1, frame_content_size=16, err=0.
- Magic 28 B5 2F FE -> err=1, in_ready drops next cycle. FHD 0x28 -> err=2.
- hdr_ready low 5 cycles with in_valid toggling -> outputs stable, in_ready=0. reset_n pulse mid-COLLECT -> all outputs 0, IDLE.
